// File: rtl/exp_pkg.sv
// Shared constants for the exp datapath: ln2 scaling, Q4.11 widths
// and the int_recon FSM state encodings.
package exp_pkg;

    localparam int X_W     = 15;
    localparam int R_W     = 16;
    localparam int I_W     = 5;
    localparam int ACC_W   = 20;
    localparam int FRAC_SH = 5;
    localparam int CNT_W   = 3;

    localparam logic [ACC_W-1:0] LN2_Q16 = 20'd45426;
    localparam logic [I_W-1:0]   I_MAX   = 5'd20;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_SUB  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/seq_const_mul.sv
// Bit-serial multiply of a 5-bit operand by LN2_Q16, MSB first.
// Ports: clk, rst, i_start/i_op load, o_done on last step, o_prod.
module seq_const_mul
    import exp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [I_W-1:0]   i_op,
    output logic             o_done,
    output logic [ACC_W-1:0] o_prod
);

    logic [ACC_W-1:0] r_acc;
    logic [I_W-1:0]   r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [ACC_W-1:0] w_add;

    // Operand shifts left so its MSB is always the bit being consumed.
    assign w_add  = r_op[I_W-1] ? LN2_Q16 : '0;
    assign o_done = r_busy && (r_cnt == '0);
    assign o_prod = r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_op   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_acc  <= '0;
            r_op   <= i_op;
            r_cnt  <= CNT_W'(I_W - 1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_acc <= {r_acc[ACC_W-2:0], 1'b0} + w_add;
            r_op  <= {r_op[I_W-2:0], 1'b0};
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_recon.sv
// Reconstructs p = floor(i*ln2) in Q4.11 and residual r = x - p.
// Ports: clk, rst, in_* accept handshake, out_* result handshake.
module int_recon
    import exp_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [X_W-1:0] in_x,
    input  logic [I_W-1:0] in_i,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [R_W-1:0] out_r,
    output logic [X_W-1:0] out_p,
    output logic [I_W-1:0] out_i,
    output logic           out_err
);

    logic [1:0]       r_state;
    logic [X_W-1:0]   r_x;
    logic [I_W-1:0]   r_i;
    logic             r_err;
    logic [R_W-1:0]   r_out_r;
    logic [X_W-1:0]   r_out_p;
    logic [I_W-1:0]   r_out_i;
    logic             r_out_err;

    logic             w_start;
    logic             w_done;
    logic [ACC_W-1:0] w_prod;
    logic [X_W-1:0]   w_p;
    logic [R_W-1:0]   w_r;
    logic             w_unused_frac;

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_r     = r_out_r;
    assign out_p     = r_out_p;
    assign out_i     = r_out_i;
    assign out_err   = r_out_err;

    assign w_start = in_valid && in_ready;

    // Q.16 product -> Q.11 by dropping the low FRAC_SH bits (floor).
    assign w_p = w_prod[ACC_W-1:FRAC_SH];
    assign w_r = {1'b0, r_x} - {1'b0, w_p};
    assign w_unused_frac = ^w_prod[FRAC_SH-1:0];

    seq_const_mul u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_op    (in_i),
        .o_done  (w_done),
        .o_prod  (w_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_x       <= '0;
            r_i       <= '0;
            r_err     <= 1'b0;
            r_out_r   <= '0;
            r_out_p   <= '0;
            r_out_i   <= '0;
            r_out_err <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_x     <= in_x;
                        r_i     <= in_i;
                        r_err   <= (in_i == '0) || (in_i > I_MAX);
                        r_state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (w_done) begin
                        r_state <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    r_out_p   <= r_err ? '0 : w_p;
                    r_out_r   <= r_err ? '0 : w_r;
                    r_out_i   <= r_i;
                    r_out_err <= r_err;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_recon.sv
// Randomized bench for int_recon against an arithmetic model of
// floor(i*ln2) reconstruction, plus directed corner cases.
module tb_int_recon;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [14:0] in_x = '0;
    logic [4:0]  in_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_r;
    logic [14:0] out_p;
    logic [4:0]  out_i;
    logic        out_err;

    int n_chk = 0;
    int n_err = 0;

    int_recon dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_p     (out_p),
        .out_i     (out_i),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // floor(i * ln2) in Q4.11, from the Q0.16 constant.
    function automatic int ref_p(input int i);
        return (i * 45426) / 32;
    endfunction

    function automatic int ref_err(input int i);
        return ((i == 0) || (i > 20)) ? 1 : 0;
    endfunction

    // Selection stage: largest legal i whose p does not exceed x.
    function automatic int sel_i(input int x);
        int i;
        i = 1;
        for (int k = 1; k <= 20; k++) begin
            if (ref_p(k) <= x) i = k;
        end
        return i;
    endfunction

    task automatic run_op(input int x, input int i, input int hold,
                          input bit cons);
        int lat;
        bit ok;
        int ep, er, ee, sr;
        ee = ref_err(i);
        ep = ee ? 0 : ref_p(i);
        er = ee ? 0 : x - ref_p(i);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        in_x = x[14:0];
        in_i = i[4:0];
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_x = 15'($urandom);
        in_i = 5'($urandom);
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", lat, 6);
        if (lat == 0) return;
        sr = $signed(out_r);
        chk("p", out_p, ep);
        chk("r", sr, er);
        chk("i", out_i, i);
        chk("err", out_err, ee);
        if (cons) chk("r_range", int'(sr >= -1419 && sr <= 1419), 1);
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            in_x = 15'($urandom);
            in_i = 5'($urandom);
            @(posedge clk); #1;
            sr = $signed(out_r);
            chk("hold_valid", out_valid, 1);
            chk("hold_r", sr, er);
            chk("hold_p", out_p, ep);
            chk("hold_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("rel_valid", out_valid, 0);
        chk("rel_ready", in_ready, 1);
    endtask

    initial begin
        int seen;
        int x, i;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_r", out_r, 0);
        chk("rst_p", out_p, 0);
        chk("rst_i", out_i, 0);
        chk("rst_err", out_err, 0);

        run_op(2839, 2, 0, 1'b0);
        run_op(0, 1, 1, 1'b0);
        run_op(28671, 20, 0, 1'b1);
        run_op(4660, 0, 0, 1'b0);
        run_op(4660, 21, 2, 1'b0);
        run_op(5000, 31, 10, 1'b0);

        // Abort mid-multiply: no result may appear.
        in_valid = 1'b1;
        in_x = 15'h1234;
        in_i = 5'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_r", out_r, 0);
        chk("abort_p", out_p, 0);
        chk("abort_i", out_i, 0);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        chk("abort_novalid", seen, 0);
        chk("abort_ready", in_ready, 1);
        run_op(4096, 2, 0, 1'b0);

        for (int xs = 0; xs <= 28671; xs += 37) begin
            run_op(xs, sel_i(xs), 0, 1'b1);
        end
        run_op(28671, sel_i(28671), 0, 1'b1);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                x = $urandom_range(0, 28671);
                i = sel_i(x);
                run_op(x, i, $urandom_range(0, 2), 1'b1);
            end else begin
                x = $urandom_range(0, 32767);
                i = $urandom_range(0, 31);
                run_op(x, i, $urandom_range(0, 2), 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
